// File: rtl/cache_ctrl_4way_pkg.sv
// Shared constants, FSM state type and tree-PLRU helpers
// for the 4-way set-associative one-word-block cache controller.
package cache_pkg;

  localparam int TAG_W   = 22;
  localparam int INDEX_W = 8;
  localparam int DATA_W  = 32;
  localparam int SETS    = 1 << INDEX_W;
  localparam int WAYS    = 4;
  localparam int IDX_LSB = 2;
  localparam int TAG_LSB = IDX_LSB + INDEX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_REQ,
    MEM_WAIT,
    FILL,
    RESP
  } state_t;

  // bits = {b2, b1, b0}; b0 picks the half, b1/b2 the way inside it
  function automatic logic [1:0] plru_victim(
    input logic [2:0] bits
  );
    if (!bits[0]) return bits[1] ? 2'd1 : 2'd0;
    return bits[2] ? 2'd3 : 2'd2;
  endfunction

  function automatic logic [2:0] plru_update(
    input logic [2:0] bits,
    input logic [1:0] way
  );
    logic [2:0] n;
    n    = bits;
    n[0] = !way[1];
    if (!way[1]) n[1] = (way == 2'd0);
    else         n[2] = (way == 2'd2);
    return n;
  endfunction

endpackage

// File: rtl/cache_ctrl_4way_if.sv
// Bus bundle: processor request/response plus memory request/response.
// slave = controller view, master = processor/memory environment view.
interface cache_ctrl_4way_if;
  import cache_pkg::*;

  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic              cpu_req_we;
  logic [31:0]       cpu_req_addr;
  logic [DATA_W-1:0] cpu_req_wdata;
  logic              cpu_rsp_valid;
  logic [DATA_W-1:0] cpu_rsp_rdata;
  logic              cpu_rsp_hit;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [31:0]       mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_rdata;

  modport slave (
    input  cpu_req_valid, cpu_req_we,
    input  cpu_req_addr, cpu_req_wdata,
    output cpu_req_ready,
    output cpu_rsp_valid, cpu_rsp_rdata,
    output cpu_rsp_hit,
    output mem_req_valid, mem_req_we,
    output mem_req_addr, mem_req_wdata,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_rdata
  );

  modport master (
    output cpu_req_valid, cpu_req_we,
    output cpu_req_addr, cpu_req_wdata,
    input  cpu_req_ready,
    input  cpu_rsp_valid, cpu_rsp_rdata,
    input  cpu_rsp_hit,
    input  mem_req_valid, mem_req_we,
    input  mem_req_addr, mem_req_wdata,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_rdata
  );

endinterface

// File: rtl/cache_ctrl_4way_plru.sv
// plru_tree: victim select and next PLRU bits for one set.
// Ports: bits (current {b2,b1,b0}), way (accessed), victim, next_bits.
module plru_tree
  import cache_pkg::*;
(
  input  logic [2:0] bits,
  input  logic [1:0] way,
  output logic [1:0] victim,
  output logic [2:0] next_bits
);

  assign victim    = plru_victim(bits);
  assign next_bits = plru_update(bits, way);

endmodule

// File: rtl/cache_ctrl_4way.sv
// 4-way write-through/write-allocate cache controller, tree PLRU.
// Ports: clk, rst (async active-high), bus (slave side of the bus bundle).
module cache_ctrl_4way
  import cache_pkg::*;
(
  input logic              clk,
  input logic              rst,
  cache_ctrl_4way_if.slave bus
);

  state_t state, next;

  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] idx_q;
  logic               we_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               hit_q;

  logic [TAG_W-1:0]  tag_arr  [WAYS][SETS];
  logic [DATA_W-1:0] data_arr [WAYS][SETS];
  logic [WAYS-1:0]   valid_arr[SETS];
  logic [2:0]        plru_arr [SETS];

  logic [WAYS-1:0] set_valid, hit_vec;
  logic [1:0]      hit_way, inv_way;
  logic [1:0]      plru_vic, victim, way_sel;
  logic [2:0]      plru_nxt;
  logic            hit, arr_we, plru_we;
  logic [DATA_W-1:0] arr_data;
  logic            unused_addr;

  assign unused_addr = ^bus.cpu_req_addr[1:0];

  assign set_valid = valid_arr[idx_q];

  always_comb begin
    hit_vec = '0;
    hit_way = 2'd0;
    inv_way = 2'd0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_vec[w] = set_valid[w] &&
                   (tag_arr[w][idx_q] == tag_q);
      // descending scan: lowest way wins
      if (hit_vec[w])    hit_way = 2'(w);
      if (!set_valid[w]) inv_way = 2'(w);
    end
  end

  assign hit     = |hit_vec;
  assign victim  = (&set_valid) ? plru_vic : inv_way;
  assign way_sel = hit ? hit_way : victim;

  plru_tree u_plru (
    .bits      (plru_arr[idx_q]),
    .way       (way_sel),
    .victim    (plru_vic),
    .next_bits (plru_nxt)
  );

  assign arr_we   = (state == LOOKUP && we_q) ||
                    (state == FILL);
  assign plru_we  = (state == LOOKUP && (hit || we_q)) ||
                    (state == FILL);
  // a read miss parks the fetched word in rdata_q
  assign arr_data = (state == FILL) ? rdata_q : wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:     if (bus.cpu_req_valid) next = LOOKUP;
      LOOKUP:   next = (hit && !we_q) ? RESP : MEM_REQ;
      MEM_REQ:  if (bus.mem_req_ready) next = MEM_WAIT;
      MEM_WAIT: if (bus.mem_rsp_valid)
                  next = we_q ? RESP : FILL;
      FILL:     next = RESP;
      RESP:     next = IDLE;
      default:  next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      hit_q   <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_arr[s] <= '0;
        plru_arr[s]  <= '0;
      end
    end else begin
      if (state == IDLE && bus.cpu_req_valid) begin
        tag_q   <= bus.cpu_req_addr[31:TAG_LSB];
        idx_q   <= bus.cpu_req_addr[TAG_LSB-1:IDX_LSB];
        we_q    <= bus.cpu_req_we;
        wdata_q <= bus.cpu_req_wdata;
      end
      if (state == LOOKUP) begin
        hit_q   <= hit;
        rdata_q <= we_q ? wdata_q
                        : data_arr[hit_way][idx_q];
      end
      if (state == MEM_WAIT && bus.mem_rsp_valid && !we_q)
        rdata_q <= bus.mem_rsp_rdata;
      if (arr_we)  valid_arr[idx_q][way_sel] <= 1'b1;
      if (plru_we) plru_arr[idx_q] <= plru_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) begin
      tag_arr[way_sel][idx_q]  <= tag_q;
      data_arr[way_sel][idx_q] <= arr_data;
    end
  end

  assign bus.cpu_req_ready = (state == IDLE) && !rst;
  assign bus.cpu_rsp_valid = (state == RESP);
  assign bus.cpu_rsp_rdata = rdata_q;
  assign bus.cpu_rsp_hit   = hit_q;
  assign bus.mem_req_valid = (state == MEM_REQ);
  assign bus.mem_req_we    = we_q;
  assign bus.mem_req_addr  = {tag_q, idx_q, 2'b00};
  assign bus.mem_req_wdata = wdata_q;

endmodule

// File: doc/cache_ctrl_4way.md
# cache_ctrl_4way

Controller for the 4-way set-associative, one-word-block cache. It accepts processor read and write requests and looks up all four ways, answering hits directly from its internal tag, data and valid arrays. On a miss it runs a request/response handshake with the memory side. Policy is write-through and write-allocate, with tree pseudo-LRU replacement.

## Interface
Parameters:
- TAG_W, 22, tag width (addr[31:10])
- INDEX_W, 8, set index width (addr[9:2]); SETS = 2**INDEX_W
- DATA_W, 32, word width

Ports:
- clk  in  1  single clock; all state changes on posedge clk
- rst  in  1  reset, asynchronous and active-high
- cpu_req_valid  in  1  request present
- cpu_req_ready  out  1  controller can accept a request (high only in IDLE)
- cpu_req_we  in  1  0 = read, 1 = write
- cpu_req_addr  in  32  byte address; bits [1:0] ignored
- cpu_req_wdata  in  DATA_W  write data
- cpu_rsp_valid  out  1  one-cycle response pulse
- cpu_rsp_rdata  out  DATA_W  read data; on a write, echoes the write data
- cpu_rsp_hit  out  1  1 = request hit in the cache
- mem_req_valid  out  1  memory request, held until accepted
- mem_req_ready  in  1  memory accepts the request
- mem_req_we  out  1  0 = word fetch, 1 = write-through
- mem_req_addr  out  32  word-aligned address ({tag, index, 2'b00})
- mem_req_wdata  out  DATA_W  write-through data
- mem_rsp_valid  in  1  fetch data valid, or write acknowledge
- mem_rsp_rdata  in  DATA_W  fetched word

## Operation
- FSM states: IDLE, LOOKUP, MEM_REQ, MEM_WAIT, FILL, RESP.
- IDLE: request accepted when cpu_req_valid && cpu_req_ready. Address, we and wdata are captured.
- LOOKUP: compare the captured tag against the 4 ways of the indexed set; hit = valid && tag match. Multiple hits cannot occur; if they do, the lowest way wins.
  - Read hit: update PLRU, go to RESP with the way's data.
  - Read miss: go to MEM_REQ with mem_req_we = 0.
  - Write hit: overwrite the hit way's data and update PLRU. Go to MEM_REQ with we = 1.
  - Write miss: pick a victim, set valid, write tag and data, update PLRU. Go to MEM_REQ with we = 1.
- MEM_REQ: hold mem_req_valid and all mem_req_* fields stable until mem_req_ready is sampled high, then go to MEM_WAIT.
- MEM_WAIT: wait for mem_rsp_valid. Read: capture mem_rsp_rdata and go to FILL. Write: go to RESP.
- FILL: write the victim way (valid = 1, tag, data), update PLRU, then go to RESP.
- RESP: cpu_rsp_valid = 1 for exactly one cycle, then IDLE.
- Victim selection: the lowest-numbered invalid way; if all 4 ways are valid, the PLRU victim.
- PLRU: 3 bits per set {b2, b1, b0}.
  - Victim: b0 = 0 selects way b1 ? 1 : 0; b0 = 1 selects way b2 ? 3 : 2.
  - On access to way w: b0 = (w < 2); if w < 2 then b1 = (w == 0); else b2 = (w == 2).
- mem_rsp_valid outside MEM_WAIT is ignored.
- cpu_req_* inputs are ignored while cpu_req_ready = 0.

## Timing
- Handshake at edge E0 → LOOKUP. At E1 → RESP (hit) or MEM_REQ.
- Read hit: cpu_rsp_valid high in the cycle after E1. cpu_req_ready is high again after E2, giving at most one request per 3 cycles.
- Read miss: mem_req_valid rises the cycle after E1. The response comes 2 cycles after the mem_rsp_valid edge (FILL, then RESP).
- Write: the array update lands at E1. The response comes 1 cycle after the mem_rsp_valid edge.
- Reset values: all outputs 0, state IDLE, all valid bits 0, all PLRU bits 0. Tag and data arrays are not reset.
- Reset mid-transaction: the transaction is abandoned. mem_req_valid and cpu_rsp_valid drop immediately (asynchronously). Any later memory response is ignored.

## Structure
- Package cache_pkg holds:
  - TAG_W, INDEX_W, DATA_W and the address slicing constants;
  - the FSM state enum;
  - the PLRU victim function and the PLRU update function.
- Sub-module plru_tree: combinational victim select plus next-bits computation for one set. The PLRU bit array itself lives in the controller.

## Test plan
- Read 0x0000_0400 after reset → mem_req addr 0x400, we = 0. Memory returns 0xDEADBEEF → rsp rdata 0xDEADBEEF, hit = 0. Repeat the read → hit = 1, no mem_req, rsp in the cycle after E1.
- Read misses at 0x014, 0x414, 0x814, 0xC14 fill ways 0–3 of set 5. Read 0x1014 → evicts way 0. Then 0x014 misses and 0x414 hits.
- Write 0x414 with 0x12345678 → mem_req we = 1, addr 0x414, wdata 0x12345678. After mem ack → rsp hit = 1. Read 0x414 → hit, rdata 0x12345678.
- Read miss with mem_req_ready held low 5 cycles → mem_req_valid and mem_req_addr stable throughout, cpu_req_ready = 0, no rsp.
- rst pulse during MEM_WAIT → all outputs 0 immediately. A later mem_rsp_valid is ignored. Re-reading the same address misses.
